tx_link_arbiter: RTL and testbench



---
 rtl/tx_link_arbiter.sv | 138 +++++++++++++
 tb/tb_tx_link_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_link_arbiter.sv
// rtl/tx_link_arbiter.sv - round-robin arbiter and LSB-first serializer for the shared TX link
module tx_link_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_last,
    output logic [NUM_CH-1:0]        ch_grant,
    output logic [NUM_CH-1:0]        ch_ack,
    input  logic                     rx_ready,
    output logic                     tx_valid,
    output logic                     tx_data,
    output logic                     tx_sof,
    output logic                     tx_eop,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, ARB, WAIT_RDY, LOAD, SHIFT, GAP} state_t;

    state_t              state;
    logic [PW-1:0]       gnt_idx;
    logic [PW-1:0]       ptr;
    logic [DATA_W-1:0]   shreg;
    logic [BW-1:0]       bit_cnt;
    logic [3:0]          byte_cnt;
    logic                last_q;

    logic [PW-1:0]       pick_idx;
    logic                pick_found;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_last;
    logic                sel_req;
    logic                last_bit;
    logic                burst_end;

    // Round-robin pick: first requester at or after the pointer, wrapping
    always_comb begin
        int c;
        c          = 0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = (int'(ptr) + i) % NUM_CH;
            if (!pick_found && ch_req[c]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(c);
            end
        end
    end

    // Granted channel's byte, last flag and request, plus end-of-burst decision
    always_comb begin
        sel_data  = ch_data[int'(gnt_idx)*DATA_W +: DATA_W];
        sel_last  = ch_last[gnt_idx];
        sel_req   = ch_req[gnt_idx];
        last_bit  = (bit_cnt == BW'(DATA_W - 1));
        burst_end = last_q || (byte_cnt == 4'(MAX_BURST)) || !sel_req;
    end

    // Link-side outputs decoded from the registered state and shift register
    always_comb begin
        tx_valid   = (state == SHIFT);
        tx_data    = (state == SHIFT) && shreg[0];
        tx_sof     = (state == SHIFT) && (bit_cnt == '0) && (byte_cnt == 4'd1);
        tx_eop     = (state == SHIFT) && last_bit && burst_end;
        ch_ack     = (state == LOAD) ? ch_grant : '0;
        busy       = (state != IDLE);
        frame_done = (state == GAP);
    end

    // Burst sequencer: arbitrate, then per byte wait-ready, load, shift; gap at burst end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            ptr      <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            last_q   <= 1'b0;
            ch_grant <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|ch_req) state <= ARB;
                end
                ARB: begin
                    byte_cnt <= '0;
                    if (pick_found) begin
                        gnt_idx  <= pick_idx;
                        ch_grant <= NUM_CH'(1) << pick_idx;
                        state    <= WAIT_RDY;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_RDY: begin
                    if (rx_ready) state <= LOAD;
                end
                LOAD: begin
                    shreg    <= sel_data;
                    last_q   <= sel_last;
                    byte_cnt <= byte_cnt + 4'd1;
                    bit_cnt  <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    shreg <= shreg >> 1;
                    if (last_bit) begin
                        bit_cnt <= '0;
                        if (burst_end) begin
                            ch_grant <= '0;
                            state    <= GAP;
                        end else begin
                            state <= WAIT_RDY;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                GAP: begin
                    ptr   <= (gnt_idx == PW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_link_arbiter.sv
// tb/tb_tx_link_arbiter.sv - table-driven self-checking bench for tx_link_arbiter
module tb_tx_link_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ch_req = '0;
    logic [31:0] ch_data = '0;
    logic [3:0]  ch_last = '0;
    logic [3:0]  ch_grant;
    logic [3:0]  ch_ack;
    logic        rx_ready = 1'b1;
    logic        tx_valid, tx_data, tx_sof, tx_eop, busy, frame_done;

    always #5 clk = ~clk;

    tx_link_arbiter #(.NUM_CH(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_data(ch_data), .ch_last(ch_last),
        .ch_grant(ch_grant), .ch_ack(ch_ack), .rx_ready(rx_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_sof(tx_sof), .tx_eop(tx_eop), .busy(busy), .frame_done(frame_done)
    );

    // One scenario: per-channel byte queues plus the bursts expected on the link
    typedef struct {
        logic [3:0][7:0][7:0] data;
        logic [3:0][7:0]      last;
        logic [3:0][3:0]      len;
        logic [3:0][3:0]      drop_at;
        logic [3:0]           late;
        int                   rx_mode;
        int                   exp_gap;
        int                   chk_lat;
        int                   n_bursts;
        logic [7:0][3:0]      exp_ch;
        logic [7:0][3:0]      exp_nb;
    } row_t;

    row_t rows[8];
    row_t cur;

    int checks = 0;
    int failures = 0;

    int src_pos[4];
    int acks_ch[4];
    logic [3:0] en;
    logic [3:0] ack_pend;
    logic rx_low;
    int rx_hold;

    int nbursts, cur_ch, cur_acks, bit_idx, gap, eop_cnt, step_no;
    int first_busy, first_grant, first_ack, first_valid;
    logic [7:0] exp_byte;
    logic last_cyc_eop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int c = 0; c < 4; c++) begin
            if (ack_pend[c]) begin
                src_pos[c]++;
                acks_ch[c]++;
            end
        end
        if (|ack_pend) en = en | cur.late;
        ack_pend = '0;
        for (int c = 0; c < 4; c++) begin
            ch_req[c] = en[c] && (src_pos[c] < int'(cur.len[c])) &&
                        !((cur.drop_at[c] != 0) && (acks_ch[c] >= int'(cur.drop_at[c])));
            if (src_pos[c] < 8) begin
                ch_data[c*8 +: 8] = cur.data[c][src_pos[c]];
                ch_last[c]        = cur.last[c][src_pos[c]];
            end else begin
                ch_data[c*8 +: 8] = 8'h00;
                ch_last[c]        = 1'b0;
            end
        end
        if (rx_hold > 0) begin
            rx_ready = 1'b0;
            rx_hold--;
        end else begin
            rx_ready = !rx_low;
        end
    endtask

    task automatic monitor();
        int c;
        int bi;
        c = 0;
        step_no++;
        if (busy && first_busy < 0) first_busy = step_no;
        if (ch_grant != 0 && first_grant < 0) first_grant = step_no;
        if (ch_ack != 0 && first_ack < 0) first_ack = step_no;
        if (tx_valid && first_valid < 0) first_valid = step_no;
        if (ch_ack != 0) begin
            check("ack_is_grant", 32'(ch_ack), 32'(ch_grant));
            for (int i = 0; i < 4; i++) if (ch_ack[i]) c = i;
            if (cur_acks == 0) cur_ch = c;
            else check("ack_same_ch", c, cur_ch);
            cur_acks++;
            exp_byte = (src_pos[c] < 8) ? cur.data[c][src_pos[c]] : 8'h00;
            ack_pend = ch_ack;
        end
        if (tx_valid) begin
            bi = bit_idx % 8;
            if (bit_idx > 0 && bi == 0) check("byte_gap", gap, cur.exp_gap);
            check("tx_data", 32'(tx_data), 32'(exp_byte[bi]));
            check("tx_sof", 32'(tx_sof), 32'(bit_idx == 0));
            check("grant_hold", 32'(ch_grant), 32'(4'b0001 << cur_ch));
            if (tx_eop) eop_cnt++;
            if (cur.rx_mode == 1 && bit_idx == 3) begin
                rx_low   = 1'b1;
                rx_ready = 1'b0;
            end
            if (cur.rx_mode == 1 && bit_idx == 7) begin
                rx_low  = 1'b0;
                rx_hold = 5;
            end
            bit_idx++;
            gap = 0;
        end else begin
            gap++;
        end
        if (frame_done) begin
            check("fd_after_eop", 32'(last_cyc_eop), 1);
            check("eop_once", eop_cnt, 1);
            check("gap_idle", {27'd0, ch_grant, tx_valid}, 0);
            check("burst_bits", bit_idx, 8 * cur_acks);
            if (nbursts < cur.n_bursts) begin
                check("burst_ch", cur_ch, 32'(cur.exp_ch[nbursts]));
                check("burst_nb", cur_acks, 32'(cur.exp_nb[nbursts]));
            end
            nbursts++;
            cur_acks = 0;
            bit_idx  = 0;
            eop_cnt  = 0;
            gap      = 0;
        end
        last_cyc_eop = tx_valid && tx_eop;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            src_pos[c] = 0;
            acks_ch[c] = 0;
        end
        en = '0; ack_pend = '0; rx_low = 1'b0; rx_hold = 0;
        nbursts = 0; cur_ch = 0; cur_acks = 0; bit_idx = 0; gap = 0; eop_cnt = 0; step_no = 0;
        first_busy = -1; first_grant = -1; first_ack = -1; first_valid = -1;
        exp_byte = '0; last_cyc_eop = 1'b0;
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {20'd0, ch_grant, ch_ack, tx_valid, tx_data, tx_sof, tx_eop, busy, frame_done}, 0);
        rst_n = 1'b1;
        en = 4'hF & ~cur.late;
        drive_inputs();
    endtask

    task automatic run_row(input int r);
        int k;
        int exp_acks;
        cur = rows[r];
        do_reset();
        k = 0;
        while (nbursts < cur.n_bursts && k < 3000) begin
            step();
            k++;
        end
        check("row_done_in_budget", 32'(nbursts >= cur.n_bursts), 1);
        repeat (10) step();
        check("burst_count", nbursts, cur.n_bursts);
        check("idle_busy", 32'(busy), 0);
        for (int c = 0; c < 4; c++) begin
            exp_acks = 0;
            for (int b = 0; b < cur.n_bursts; b++)
                if (int'(cur.exp_ch[b]) == c) exp_acks += int'(cur.exp_nb[b]);
            check("acks_per_ch", acks_ch[c], exp_acks);
        end
        if (cur.chk_lat != 0) begin
            check("lat_busy", first_busy, 2);
            check("lat_grant", first_grant, 3);
            check("lat_ack", first_ack, 4);
            check("lat_valid", first_valid, 5);
        end
    endtask

    initial begin
        int k;
        for (int r = 0; r < 8; r++) begin
            rows[r] = '{default: 0};
            rows[r].exp_gap = 2;
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < 8; b++)
                    rows[r].data[c][b] = 8'(8'h5A ^ (c * 37 + b * 11 + r * 5));
        end
        // Ch0 alone: 0xA5 then 0x3C (last), latency checked
        rows[0].data[0][0] = 8'hA5; rows[0].data[0][1] = 8'h3C;
        rows[0].len[0] = 4'd2; rows[0].last[0] = 8'b0000_0010; rows[0].chk_lat = 1;
        rows[0].n_bursts = 1; rows[0].exp_ch[0] = 4'd0; rows[0].exp_nb[0] = 4'd2;
        // All four channels, one-byte packets: round-robin order twice
        for (int c = 0; c < 4; c++) begin
            rows[1].len[c] = 4'd2; rows[1].last[c] = 8'hFF;
        end
        rows[1].n_bursts = 8;
        for (int b = 0; b < 8; b++) begin
            rows[1].exp_ch[b] = 4'(b % 4); rows[1].exp_nb[b] = 4'd1;
        end
        // Ch2 never sets last: capped at 4 bytes, then ch3 is next
        rows[2].len[2] = 4'd5; rows[2].len[1] = 4'd1; rows[2].len[3] = 4'd1;
        rows[2].last[1] = 8'hFF; rows[2].last[3] = 8'hFF; rows[2].late = 4'b1010;
        rows[2].n_bursts = 4;
        rows[2].exp_ch[0] = 4'd2; rows[2].exp_nb[0] = 4'd4;
        rows[2].exp_ch[1] = 4'd3; rows[2].exp_nb[1] = 4'd1;
        rows[2].exp_ch[2] = 4'd1; rows[2].exp_nb[2] = 4'd1;
        rows[2].exp_ch[3] = 4'd2; rows[2].exp_nb[3] = 4'd1;
        // Ch1 drops its request mid byte 2
        rows[3].len[1] = 4'd4; rows[3].drop_at[1] = 4'd2;
        rows[3].n_bursts = 1; rows[3].exp_ch[0] = 4'd1; rows[3].exp_nb[0] = 4'd2;
        // rx_ready low from bit 3 of byte 1 until 5 cycles after it
        rows[4].data[0][0] = 8'h96; rows[4].data[0][1] = 8'h0F;
        rows[4].len[0] = 4'd2; rows[4].last[0] = 8'b0000_0010; rows[4].rx_mode = 1; rows[4].exp_gap = 7;
        rows[4].n_bursts = 1; rows[4].exp_ch[0] = 4'd0; rows[4].exp_nb[0] = 4'd2;
        // Ch1 two-byte packet then a tail byte, interleaved with ch3
        rows[5].len[1] = 4'd3; rows[5].last[1] = 8'b0000_0010;
        rows[5].len[3] = 4'd2; rows[5].last[3] = 8'hFF;
        rows[5].n_bursts = 4;
        rows[5].exp_ch[0] = 4'd1; rows[5].exp_nb[0] = 4'd2;
        rows[5].exp_ch[1] = 4'd3; rows[5].exp_nb[1] = 4'd1;
        rows[5].exp_ch[2] = 4'd1; rows[5].exp_nb[2] = 4'd1;
        rows[5].exp_ch[3] = 4'd3; rows[5].exp_nb[3] = 4'd1;
        // After reset: ch0 and ch1 both requesting, ch0 wins
        rows[6].len[0] = 4'd4; rows[6].len[1] = 4'd2; rows[6].last[1] = 8'b0000_0010;
        rows[6].n_bursts = 2;
        rows[6].exp_ch[0] = 4'd0; rows[6].exp_nb[0] = 4'd4;
        rows[6].exp_ch[1] = 4'd1; rows[6].exp_nb[1] = 4'd2;
        // Pre-reset traffic: ch1 one byte moves the pointer, then ch0 starts
        rows[7].len[1] = 4'd1; rows[7].last[1] = 8'hFF; rows[7].len[0] = 4'd4; rows[7].late = 4'b0001;
        rows[7].n_bursts = 1; rows[7].exp_ch[0] = 4'd1; rows[7].exp_nb[0] = 4'd1;

        for (int r = 0; r < 7; r++) run_row(r);

        // Reset asserted during bit 5 of ch0's first byte aborts at once
        cur = rows[7];
        do_reset();
        k = 0;
        while (!(nbursts == 1 && bit_idx == 5) && k < 500) begin
            step();
            k++;
        end
        check("reset_point_reached", 32'(nbursts == 1 && bit_idx == 5), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(tx_valid), 0);
        check("async_rst_grant", 32'(ch_grant), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_ack_fd", {30'd0, |ch_ack, frame_done}, 0);
        run_row(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
